serial_pattern_tx: RTL and testbench

Serial bit-pattern transmitter. It is the driving end of the single-bit stream that the Mealy sequence detectors consume.
- Loads a parallel pattern, a length and a repeat count.
- Shifts the pattern out MSB-first, one bit per clock, on `w`, back-to-back for the requested number of frames.
- Signals completion with a one-cycle `done` pulse.
- Used as on-chip stimulus for detector FSMs and as a general serializer.

---
 rtl/serial_pattern_tx.sv | 147 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts pattern[len-1:0] out MSB-first on w, (reps+1) frames back-to-back.
// Optional even-parity bit after each frame when TX_PARITY_EN is defined.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_idx;
    logic [CNT_W-1:0] frames_left;
    logic             len_ok;
    logic             frame_end;
`ifdef TX_PARITY_EN
    logic             par_q;
    logic             par_phase;
`endif

    // Bit select with a full-width index, so len-1 can address the field without width games.
    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == LEN_W'(i)) b = p[i];
        end
        return b;
    endfunction

`ifdef TX_PARITY_EN
    function automatic logic field_parity(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) < l) acc = acc ^ p[i];
        end
        return acc;
    endfunction
`endif

    assign len_ok = (len != '0) && (len <= LEN_W'(WIDTH));

`ifdef TX_PARITY_EN
    assign frame_end = par_phase;
`else
    assign frame_end = (bit_idx == '0);
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            bit_idx     <= '0;
            frames_left <= '0;
            w           <= 1'b0;
            w_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef TX_PARITY_EN
            par_q       <= 1'b0;
            par_phase   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start && len_ok) begin
                        state       <= SHIFT;
                        pat_q       <= pattern;
                        len_q       <= len;
                        frames_left <= reps;
                        bit_idx     <= len - LEN_W'(1);
                        w           <= bit_at(pattern, len - LEN_W'(1));
                        w_valid     <= 1'b1;
                        busy        <= 1'b1;
`ifdef TX_PARITY_EN
                        par_q       <= field_parity(pattern, len);
                        par_phase   <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (frame_end) begin
`ifdef TX_PARITY_EN
                        par_phase <= 1'b0;
`endif
                        // Next frame's first bit follows immediately; no idle gap between frames.
                        if (frames_left != '0) begin
                            frames_left <= frames_left - CNT_W'(1);
                            bit_idx     <= len_q - LEN_W'(1);
                            w           <= bit_at(pat_q, len_q - LEN_W'(1));
                        end else begin
                            state   <= DONE;
                            w       <= 1'b0;
                            w_valid <= 1'b0;
                            done    <= 1'b1;
                        end
`ifdef TX_PARITY_EN
                    end else if (bit_idx == '0) begin
                        par_phase <= 1'b1;
                        w         <= par_q;
`endif
                    end else begin
                        bit_idx <= bit_idx - LEN_W'(1);
                        w       <= bit_at(pat_q, bit_idx - LEN_W'(1));
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx; parity expectations enabled by TX_PARITY_EN.
module tb_serial_pattern_tx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clr;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    serial_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {w, w_valid, busy, done} against the expected tuple.
    task automatic checkOutput(input string tag, input logic ew, input logic ev,
                               input logic eb, input logic ed);
        checks++;
        assert ({w, w_valid, busy, done} === {ew, ev, eb, ed}) else begin
            failures++;
            $error("[TB] FAIL %s: w/valid/busy/done got %b%b%b%b required %b%b%b%b",
                   tag, w, w_valid, busy, done, ew, ev, eb, ed);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge where the first bit is visible.
    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                                 input logic [CNT_W-1:0] r);
        @(negedge clk);
        start   = 1'b1;
        pattern = p;
        len     = l;
        reps    = r;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic checkBits(input string tag, input logic [WIDTH-1:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            checkOutput(tag, exp[i], 1'b1, 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic checkParity(input string tag, input logic p);
`ifdef TX_PARITY_EN
        checkOutput(tag, p, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
`else
        if (p === 1'bx) $display("[TB] note %s", tag);
`endif
    endtask

    task automatic checkDoneIdle(input string tag);
        checkOutput({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr     = 1'b0;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        #12;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        clr = 1'b1;

        // Basic frame: 0110 then done.
        applyStimulus(16'h0006, 5'd4, 4'd0);
        checkBits("basic", 16'b0110, 4);
        checkParity("basic_par", 1'b0);
        checkDoneIdle("basic");

        // Three frames of 101 back-to-back.
        applyStimulus(16'h0005, 5'd3, 4'd2);
        checkBits("rep_f0", 16'b101, 3);
        checkParity("rep_p0", 1'b0);
        checkBits("rep_f1", 16'b101, 3);
        checkParity("rep_p1", 1'b0);
        checkBits("rep_f2", 16'b101, 3);
        checkParity("rep_p2", 1'b0);
        checkDoneIdle("rep");

        // Illegal lengths are ignored.
        applyStimulus(16'hFFFF, 5'd0, 4'd0);
        checkOutput("len0_a", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("len0_b", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 5'd17, 4'd0);
        checkOutput("len17_a", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("len17_b", 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart attempts during SHIFT and DONE must not disturb 11000011.
        applyStimulus(16'h00C3, 5'd8, 4'd0);
        checkBits("mid_head", 16'b110, 3);
        start   = 1'b1;
        pattern = 16'hFFFF;
        len     = 5'd4;
        reps    = 4'd3;
        checkBits("mid_tail", 16'b00011, 5);
        checkParity("mid_par", 1'b0);
        checkDoneIdle("mid");
        start = 1'b0;
        @(negedge clk);
        checkOutput("mid_idle2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the second bit.
        applyStimulus(16'h00F0, 5'd8, 4'd0);
        checkOutput("arst_bit0", 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("arst_bit1", 1'b1, 1'b1, 1'b1, 1'b0);
        clr = 1'b0;
        #1;
        checkOutput("arst_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("arst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        applyStimulus(16'h00A5, 5'd8, 4'd0);
        checkBits("post_rst", 16'b10100101, 8);
        checkParity("post_rst_par", 1'b0);
        checkDoneIdle("post_rst");

        // Full-width pattern, maximum repeat count: 16 frames of 1000000000000001.
        applyStimulus(16'h8001, 5'd16, 4'd15);
        for (int f = 0; f < 16; f++) begin
            checkBits("bound", 16'b1000000000000001, 16);
            checkParity("bound_par", 1'b0);
        end
        checkDoneIdle("bound");

`ifdef TX_PARITY_EN
        // 1011 has odd weight, so each frame carries a parity bit of 1.
        applyStimulus(16'h000B, 5'd4, 4'd1);
        checkBits("par", 16'b1011110111, 10);
        checkDoneIdle("par");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
